ram_sample_writer: RTL and testbench
====================================

// Module: ram_sample_writer
// PURPOSE
//  Avalon-MM write master that logs a non-stallable 32-bit sample stream (counter/PWM duty
//  snapshots) into the 5120x32 on-chip RAM slave, directly upstream of it. Samples buffer in a
//  small FIFO and are written as full words at BASE+offset, one-shot or circular. A 4-reg CSR
//  slave (Nios side) configures, starts, stops and reports status.
// PARAMETERS
//  ADDR_W      13    RAM word-address width
//  DATA_W      32    sample / RAM word width
//  DEPTH_WORDS 5120  RAM depth; physical address wraps at this value
//  FIFO_DEPTH  4     sample FIFO entries (power of 2)
// PORTS
//  clk             in   1       system clock, sole clock domain
//  reset           in   1       synchronous, active-high
//  sample_valid    in   1       one sample per cycle when high; source cannot stall
//  sample_data     in   DATA_W  sample value
//  avm_address     out  ADDR_W  RAM word address
//  avm_chipselect  out  1       = avm_write
//  avm_write       out  1       write request
//  avm_byteenable  out  4       constant 4'hF
//  avm_writedata   out  DATA_W  word to write
//  avm_waitrequest in   1       stall; tie 0 for direct RAM connection
//  s_address       in   2       CSR word select
//  s_chipselect    in   1       CSR select
//  s_read          in   1       CSR read strobe
//  s_write         in   1       CSR write strobe
//  s_writedata     in   32      CSR write data
//  s_readdata      out  32      CSR read data, registered, 1-cycle latency
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; FIFO empty; BASE=0, LENGTH=0, offset=0, all flags 0.
//  CSR map: 0 CTRL  [0] enable (RW), [1] circular (RW), [2] clear (W1, self-clearing, reads 0)
//           1 BASE  [ADDR_W-1:0] RW;  2 LENGTH [ADDR_W:0] RW (0 => DEPTH_WORDS)
//           3 STATUS RO: [12:0] offset, [16] done, [17] overflow (sticky), [18] busy
//  - BASE/LENGTH writes ignored while busy; writes to STATUS ignored; unused bits read 0.
//  FSM IDLE -> RUN on enable 0->1 (offset:=0, done:=0); RUN -> DRAIN on enable cleared or
//   one-shot length reached; DRAIN -> IDLE (enable cleared) or DONE (length reached) once
//   FIFO empty and no write pending; DONE -> RUN on enable 0->1. busy = RUN|DRAIN.
//  Capture: in RUN only, sample_valid pushes FIFO; push when full (and no pop that cycle)
//   drops the sample and sets overflow. Push+pop in same cycle on full FIFO: accepted.
//   One-shot: samples beyond LENGTH accepted-count are discarded without overflow.
//  Master: FIFO head not empty -> assert avm_write with address/data; hold address, data,
//   write stable while avm_waitrequest=1; pop and advance offset on cycle with write &
//   !waitrequest. Min latency sample_valid -> avm_write = 1 cycle (FIFO registered);
//   sustained throughput 1 word/cycle with waitrequest=0.
//  Address = BASE+offset computed ADDR_W+1 bits; if >= DEPTH_WORDS subtract DEPTH_WORDS.
//   offset increments 0..LENGTH-1; circular: wraps to 0, never sets done; one-shot: after
//   write LENGTH-1 completes, done:=1.
//  clear: flushes FIFO, offset:=0, done:=0, overflow:=0, state:=IDLE and enable:=0; an
//   in-flight write held by waitrequest completes first (address/data unchanged), then clear
//   applies. clear + enable in same CSR write: clear wins, enable stays 0.
//  s_readdata updates the cycle after s_chipselect&s_read, otherwise holds.
// STRUCTURE
//  Package ram_writer_pkg: CSR offsets, CTRL/STATUS bit indices, state enum
//   {IDLE,RUN,DRAIN,DONE}, constant byteenable 4'hF.
//  Sub-module sample_fifo: sync show-ahead FIFO (DATA_W x FIFO_DEPTH) with full/empty flags.
//  Top: CSR regs, FSM, offset/address arithmetic, master handshake.
// TESTING
//  1 BASE=100, LENGTH=8, one-shot, 10 consecutive samples 1..10 -> writes 1..8 to 100..107,
//    done=1, overflow=0, state DONE.
//  2 BASE=5118, LENGTH=4 -> addresses 5118,5119,0,1 (RAM-end wrap).
//  3 circular LENGTH=3, 7 samples A..G -> addresses BASE+0,1,2,0,1,2,0; final offset=1, done=0.
//  4 waitrequest high 10 cycles on first write, 6-sample burst -> address/data stable while
//    stalled, 4 samples kept, 2 dropped, overflow=1, kept data written in order.
//  5 clear during stalled write -> held write completes once, then no writes, offset=0,
//    flags 0, enable reads 0.
//  6 disable mid-run with 3 in FIFO -> 3 drained, then IDLE, busy=0; BASE write while busy ignored.

Source files
------------

// File: rtl/ram_writer_pkg.sv
// ram_writer_pkg
//  Shared definitions for the RAM sample writer: CSR word offsets, CTRL and
//  STATUS bit positions, the controller state encoding and the constant
//  Avalon byte-enable pattern.
//  No ports (package only).
package ram_writer_pkg;

    // CSR word offsets (s_address)
    localparam logic [1:0] CSR_CTRL   = 2'd0;
    localparam logic [1:0] CSR_BASE   = 2'd1;
    localparam logic [1:0] CSR_LENGTH = 2'd2;
    localparam logic [1:0] CSR_STATUS = 2'd3;

    // CTRL bit positions
    localparam int CTRL_ENABLE_BIT   = 0;
    localparam int CTRL_CIRCULAR_BIT = 1;
    localparam int CTRL_CLEAR_BIT    = 2;

    // STATUS bit positions (offset occupies the low bits)
    localparam int STAT_DONE_BIT     = 16;
    localparam int STAT_OVERFLOW_BIT = 17;
    localparam int STAT_BUSY_BIT     = 18;

    // Every write is a full word
    localparam logic [3:0] AVM_BYTEENABLE = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } wr_state_t;

endpackage

// File: rtl/sample_fifo.sv
// sample_fifo
//  Synchronous show-ahead FIFO: the oldest entry is always visible on
//  head_data while the FIFO is not empty. A push into a full FIFO is accepted
//  only when a pop happens in the same cycle; otherwise it is ignored (the
//  caller accounts for the drop). flush empties the FIFO in one cycle.
// Ports
//  clk, reset     clock, synchronous active-high reset
//  flush          discard all entries
//  push/push_data write request and data
//  pop            remove head entry (ignored when empty)
//  head_data      current head entry
//  full, empty    occupancy flags
module sample_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W:0]    count_reg;
    logic [DATA_W-1:0] mem_reg [DEPTH];

    logic do_push;
    logic do_pop;

    assign full    = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a sample when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);

    assign head_data = mem_reg[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage is pure datapath: no reset needed, contents are qualified by count
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (do_push && (wr_ptr_reg == PTR_W'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/ram_sample_writer.sv
// ram_sample_writer
//  Avalon-MM write master that logs a non-stallable sample stream into an
//  on-chip RAM. Samples are buffered in a small FIFO and written as full words
//  at BASE+offset (wrapping at the physical RAM end), one-shot or circular.
//  A 4-register CSR slave configures, starts, stops and reports status.
// Ports
//  clk, reset        clock, synchronous active-high reset
//  sample_valid/data sample stream (cannot be stalled)
//  avm_*             Avalon-MM write master towards the RAM
//  s_*               Avalon-MM CSR slave (registered read data, 1-cycle latency)
module ram_sample_writer
    import ram_writer_pkg::*;
#(
    parameter int ADDR_W      = 13,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 5120,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic [3:0]        avm_byteenable,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic              avm_waitrequest,
    input  logic [1:0]        s_address,
    input  logic              s_chipselect,
    input  logic              s_read,
    input  logic              s_write,
    input  logic [31:0]       s_writedata,
    output logic [31:0]       s_readdata
);

    localparam int LEN_W = ADDR_W + 1;
    localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(DEPTH_WORDS);

    // Registers
    wr_state_t         state_reg;
    logic              enable_reg;
    logic              circular_reg;
    logic [ADDR_W-1:0] base_reg;
    logic [LEN_W-1:0]  length_reg;
    logic [ADDR_W-1:0] offset_reg;
    logic [LEN_W-1:0]  accepted_reg;
    logic              done_reg;
    logic              overflow_reg;
    logic              clear_pending_reg;
    logic [31:0]       readdata_reg;

    // FIFO interface
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;

    // Control decode
    logic              csr_wr;
    logic              csr_rd;
    logic              ctrl_wr;
    logic              clear_cmd;
    logic              start_cmd;
    logic              busy;
    logic [LEN_W-1:0]  len_eff;
    logic              write_active;
    logic              stall;
    logic              pop;
    logic              clear_req;
    logic              clear_apply;
    logic              last_offset;
    logic              quota_hit;
    logic              capture;
    logic              accept;
    logic              drop;
    logic [LEN_W-1:0]  addr_sum;
    logic [ADDR_W-1:0] addr_phys;
    logic [31:0]       csr_rdata;
    logic              csr_unused;

    assign csr_wr    = s_chipselect && s_write;
    assign csr_rd    = s_chipselect && s_read;
    assign ctrl_wr   = csr_wr && (s_address == CSR_CTRL);
    assign clear_cmd = ctrl_wr && s_writedata[CTRL_CLEAR_BIT];
    // Only a 0->1 transition of enable starts a capture; clear in the same
    // write suppresses it
    assign start_cmd = ctrl_wr && s_writedata[CTRL_ENABLE_BIT] && !s_writedata[CTRL_CLEAR_BIT]
                       && !enable_reg && !clear_pending_reg;
    assign busy      = (state_reg == RUN) || (state_reg == DRAIN);
    assign len_eff   = (length_reg == '0) ? DEPTH_LEN : length_reg;

    assign write_active = !fifo_empty;
    assign stall        = write_active && avm_waitrequest;
    assign pop          = write_active && !avm_waitrequest;

    // A clear waits behind a write held by waitrequest so the RAM sees the
    // original address/data complete exactly once
    assign clear_req   = clear_cmd || clear_pending_reg;
    assign clear_apply = clear_req && !stall;

    assign last_offset = ({1'b0, offset_reg} == (len_eff - LEN_W'(1)));
    assign quota_hit   = !circular_reg && (accepted_reg >= len_eff);
    assign capture     = (state_reg == RUN) && sample_valid && !clear_req && !quota_hit;
    assign accept      = capture && (!fifo_full || pop);
    assign drop        = capture && fifo_full && !pop;

    // Physical address wraps at the RAM end
    assign addr_sum = {1'b0, base_reg} + {1'b0, offset_reg};
    always_comb begin
        addr_phys = addr_sum[ADDR_W-1:0];
        if (addr_sum >= DEPTH_LEN) begin
            addr_phys = ADDR_W'(addr_sum - DEPTH_LEN);
        end
    end

    // Master outputs follow registered state only
    assign avm_write      = write_active;
    assign avm_chipselect = write_active;
    assign avm_byteenable = AVM_BYTEENABLE;
    assign avm_address    = write_active ? addr_phys : '0;
    assign avm_writedata  = write_active ? fifo_head : '0;
    assign s_readdata     = readdata_reg;

    assign csr_unused = &{1'b0, s_writedata[31:LEN_W]};

    always_comb begin
        csr_rdata = '0;
        case (s_address)
            CSR_CTRL: begin
                csr_rdata[CTRL_ENABLE_BIT]   = enable_reg;
                csr_rdata[CTRL_CIRCULAR_BIT] = circular_reg;
            end
            CSR_BASE:   csr_rdata[ADDR_W-1:0] = base_reg;
            CSR_LENGTH: csr_rdata[LEN_W-1:0]  = length_reg;
            default: begin
                csr_rdata[ADDR_W-1:0]        = offset_reg;
                csr_rdata[STAT_DONE_BIT]     = done_reg;
                csr_rdata[STAT_OVERFLOW_BIT] = overflow_reg;
                csr_rdata[STAT_BUSY_BIT]     = busy;
            end
        endcase
    end

    sample_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (clear_apply),
        .push      (capture),
        .push_data (sample_data),
        .pop       (pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= IDLE;
            enable_reg        <= 1'b0;
            circular_reg      <= 1'b0;
            base_reg          <= '0;
            length_reg        <= '0;
            offset_reg        <= '0;
            accepted_reg      <= '0;
            done_reg          <= 1'b0;
            overflow_reg      <= 1'b0;
            clear_pending_reg <= 1'b0;
            readdata_reg      <= '0;
        end else begin
            // CSR writes
            if (ctrl_wr) begin
                enable_reg   <= s_writedata[CTRL_ENABLE_BIT] && !s_writedata[CTRL_CLEAR_BIT];
                circular_reg <= s_writedata[CTRL_CIRCULAR_BIT];
            end
            if (csr_wr && (s_address == CSR_BASE) && !busy) begin
                base_reg <= s_writedata[ADDR_W-1:0];
            end
            if (csr_wr && (s_address == CSR_LENGTH) && !busy) begin
                length_reg <= s_writedata[LEN_W-1:0];
            end
            if (csr_rd) begin
                readdata_reg <= csr_rdata;
            end

            clear_pending_reg <= clear_req && stall;

            // Capture accounting
            if (drop) begin
                overflow_reg <= 1'b1;
            end
            if (accept && !circular_reg) begin
                accepted_reg <= accepted_reg + LEN_W'(1);
            end

            // Write completion
            if (pop) begin
                offset_reg <= last_offset ? '0 : offset_reg + ADDR_W'(1);
                if (!circular_reg && last_offset) begin
                    done_reg <= 1'b1;
                end
            end

            case (state_reg)
                IDLE, DONE: begin
                    if (start_cmd) begin
                        state_reg    <= RUN;
                        offset_reg   <= '0;
                        done_reg     <= 1'b0;
                        accepted_reg <= '0;
                    end
                end
                RUN: begin
                    if (!enable_reg || quota_hit) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    // done_reg is already set by the final one-shot write
                    if (fifo_empty) begin
                        state_reg <= done_reg ? DONE : IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            // Clear overrides everything once no write is held on the bus
            if (clear_apply) begin
                state_reg    <= IDLE;
                enable_reg   <= 1'b0;
                offset_reg   <= '0;
                accepted_reg <= '0;
                done_reg     <= 1'b0;
                overflow_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ram_sample_writer.sv
module tb_ram_sample_writer;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_BASE   = 2'd1;
    localparam logic [1:0] A_LENGTH = 2'd2;
    localparam logic [1:0] A_STATUS = 2'd3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              sample_valid = 1'b0;
    logic [DATA_W-1:0] sample_data = '0;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_chipselect;
    logic              avm_write;
    logic [3:0]        avm_byteenable;
    logic [DATA_W-1:0] avm_writedata;
    logic              avm_waitrequest = 1'b0;
    logic [1:0]        s_address = '0;
    logic              s_chipselect = 1'b0;
    logic              s_read = 1'b0;
    logic              s_write = 1'b0;
    logic [31:0]       s_writedata = '0;
    logic [31:0]       s_readdata;

    ram_sample_writer dut (
        .clk             (clk),
        .reset           (reset),
        .sample_valid    (sample_valid),
        .sample_data     (sample_data),
        .avm_address     (avm_address),
        .avm_chipselect  (avm_chipselect),
        .avm_write       (avm_write),
        .avm_byteenable  (avm_byteenable),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest),
        .s_address       (s_address),
        .s_chipselect    (s_chipselect),
        .s_read          (s_read),
        .s_write         (s_write),
        .s_writedata     (s_writedata),
        .s_readdata      (s_readdata)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];

    // Completed RAM writes, sampled mid-cycle where bus signals are stable
    always @(negedge clk) begin
        if (!reset && avm_write && !avm_waitrequest) begin
            log_addr.push_back(32'(avm_address));
            log_data.push_back(avm_writedata);
            $display("  ram write addr=%0d data=0x%08h", avm_address, avm_writedata);
        end
    end

    typedef struct {
        bit          do_wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } csr_vec_t;

    csr_vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
        s_address    = a;
        s_writedata  = d;
        s_chipselect = 1'b1;
        s_write      = 1'b1;
        tick();
        s_chipselect = 1'b0;
        s_write      = 1'b0;
    endtask

    task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
        s_address    = a;
        s_chipselect = 1'b1;
        s_read       = 1'b1;
        tick();
        s_chipselect = 1'b0;
        s_read       = 1'b0;
        d = s_readdata;
    endtask

    task automatic send_samples(input logic [31:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            sample_valid = 1'b1;
            sample_data  = first + 32'(i);
            tick();
        end
        sample_valid = 1'b0;
    endtask

    // Compare the logged writes with the expected list, then reset both
    task automatic check_log(input string name);
        int n;
        check({name, "_count"}, 32'(log_addr.size()), 32'(exp_addr.size()));
        n = (log_addr.size() < exp_addr.size()) ? log_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_addr%0d", name, i), log_addr[i], exp_addr[i]);
            check($sformatf("%s_data%0d", name, i), log_data[i], exp_data[i]);
        end
        log_addr.delete();
        log_data.delete();
        exp_addr.delete();
        exp_data.delete();
    endtask

    logic [31:0] rd;

    initial begin
        // CSR register table: optional write, then read back the same word
        vecs[0] = '{1'b0, A_STATUS, 32'h0,         32'h0,    "reset_status"};
        vecs[1] = '{1'b0, A_CTRL,   32'h0,         32'h0,    "reset_ctrl"};
        vecs[2] = '{1'b1, A_BASE,   32'hFFFF_FFFF, 32'h1FFF, "base_mask"};
        vecs[3] = '{1'b1, A_LENGTH, 32'hFFFF_FFFF, 32'h3FFF, "length_mask"};
        vecs[4] = '{1'b1, A_CTRL,   32'h0000_0006, 32'h2,    "ctrl_clear_reads0"};
        vecs[5] = '{1'b1, A_STATUS, 32'hFFFF_FFFF, 32'h0,    "status_ro"};
        vecs[6] = '{1'b1, A_CTRL,   32'h0,         32'h0,    "ctrl_zero"};

        repeat (3) tick();
        reset = 1'b0;
        tick();

        check("reset_avm_write", 32'(avm_write), 32'h0);
        check("reset_avm_address", 32'(avm_address), 32'h0);
        check("reset_avm_writedata", avm_writedata, 32'h0);
        check("reset_s_readdata", s_readdata, 32'h0);

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].do_wr) csr_write(vecs[i].addr, vecs[i].wdata);
            csr_read(vecs[i].addr, rd);
            check(vecs[i].name, rd, vecs[i].exp);
        end
        tick();
        check("readdata_holds", s_readdata, 32'h0);
        csr_read(A_BASE, rd);
        tick();
        check("readdata_holds_base", s_readdata, 32'h1FFF);

        // 1: one-shot, BASE=100, LENGTH=8, ten samples
        csr_write(A_BASE, 32'd100);
        csr_write(A_LENGTH, 32'd8);
        csr_write(A_CTRL, 32'h1);
        sample_valid = 1'b1;
        sample_data  = 32'd1;
        tick();
        check("t1_latency_write", 32'(avm_write), 32'h1);
        check("t1_latency_addr", 32'(avm_address), 32'd100);
        check("t1_latency_data", avm_writedata, 32'd1);
        send_samples(32'd2, 9);
        repeat (10) tick();
        for (int i = 0; i < 8; i++) begin
            exp_addr.push_back(32'(100 + i));
            exp_data.push_back(32'(1 + i));
        end
        check_log("t1");
        csr_read(A_STATUS, rd);
        check("t1_status_flags", rd & 32'h0007_0000, 32'h0001_0000);

        // 2: RAM-end wrap
        csr_write(A_CTRL, 32'h0);
        csr_write(A_BASE, 32'd5118);
        csr_write(A_LENGTH, 32'd4);
        csr_write(A_CTRL, 32'h1);
        send_samples(32'h20, 4);
        repeat (8) tick();
        exp_addr = '{32'd5118, 32'd5119, 32'd0, 32'd1};
        exp_data = '{32'h20, 32'h21, 32'h22, 32'h23};
        check_log("t2");

        // 3: circular, LENGTH=3, seven samples
        csr_write(A_CTRL, 32'h0);
        csr_write(A_BASE, 32'd200);
        csr_write(A_LENGTH, 32'd3);
        csr_write(A_CTRL, 32'h3);
        send_samples(32'hA, 7);
        repeat (8) tick();
        for (int i = 0; i < 7; i++) begin
            exp_addr.push_back(32'(200 + (i % 3)));
            exp_data.push_back(32'(10 + i));
        end
        check_log("t3");
        csr_read(A_STATUS, rd);
        check("t3_status_running", rd, 32'h0004_0001);
        csr_write(A_CTRL, 32'h0);
        repeat (5) tick();
        csr_read(A_STATUS, rd);
        check("t3_status_stopped", rd, 32'h0000_0001);

        // 4: waitrequest stall with a 6-sample burst
        csr_write(A_BASE, 32'd300);
        csr_write(A_LENGTH, 32'd0);
        avm_waitrequest = 1'b1;
        csr_write(A_CTRL, 32'h1);
        for (int i = 0; i < 10; i++) begin
            sample_valid = (i < 6);
            sample_data  = 32'h40 + 32'(i);
            tick();
            check($sformatf("t4_stall_addr%0d", i), 32'(avm_address), 32'd300);
            check($sformatf("t4_stall_data%0d", i), avm_writedata, 32'h40);
        end
        sample_valid = 1'b0;
        avm_waitrequest = 1'b0;
        repeat (8) tick();
        for (int i = 0; i < 4; i++) begin
            exp_addr.push_back(32'(300 + i));
            exp_data.push_back(32'h40 + 32'(i));
        end
        check_log("t4");
        csr_read(A_STATUS, rd);
        check("t4_status", rd, 32'h0006_0004);
        csr_write(A_CTRL, 32'h0);
        repeat (4) tick();

        // 5: clear while a write is held by waitrequest
        csr_write(A_CTRL, 32'h1);
        avm_waitrequest = 1'b1;
        send_samples(32'h50, 2);
        csr_write(A_CTRL, 32'h4);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t5_held_write%0d", i), 32'(avm_write), 32'h1);
            check($sformatf("t5_held_addr%0d", i), 32'(avm_address), 32'd300);
            check($sformatf("t5_held_data%0d", i), avm_writedata, 32'h50);
        end
        avm_waitrequest = 1'b0;
        repeat (6) tick();
        exp_addr = '{32'd300};
        exp_data = '{32'h50};
        check_log("t5");
        check("t5_write_idle", 32'(avm_write), 32'h0);
        csr_read(A_STATUS, rd);
        check("t5_status", rd, 32'h0);
        csr_read(A_CTRL, rd);
        check("t5_ctrl", rd, 32'h0);

        // 6: disable mid-run with three samples queued
        csr_write(A_BASE, 32'd400);
        csr_write(A_CTRL, 32'h1);
        avm_waitrequest = 1'b1;
        send_samples(32'h60, 3);
        csr_write(A_CTRL, 32'h0);
        csr_write(A_BASE, 32'd999);
        send_samples(32'h70, 2);
        avm_waitrequest = 1'b0;
        repeat (8) tick();
        exp_addr = '{32'd400, 32'd401, 32'd402};
        exp_data = '{32'h60, 32'h61, 32'h62};
        check_log("t6");
        csr_read(A_STATUS, rd);
        check("t6_status", rd, 32'h0000_0003);
        csr_read(A_BASE, rd);
        check("t6_base_kept", rd, 32'd400);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
